// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM states, default tap masks and seed sanitising for lfsr_stat_gen
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Maximal-length tap masks, bit i set means state bit i feeds the XOR
    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

    // An all-zero state never leaves zero, so it is replaced by 1
    function automatic logic [31:0] sanitise_seed(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with load priority over enable
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 13,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RESET_VALUE;
        end else if (load) begin
            state <= load_value;
        end else if (en) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/lfsr_stat_gen.sv
// rtl/lfsr_stat_gen.sv - LFSR PRBS generator with period detect and ones/zeros stats (LFSR_STATS_EN)
module lfsr_stat_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             prbs_bit,
    output logic             max_tick,
    output logic [CNT_W-1:0] final_ones,
    output logic [CNT_W-1:0] final_zeros,
    output logic             running
);

    localparam logic [WIDTH-1:0] SEED_CLEAN = WIDTH'(sanitise_seed(32'(SEED)));

    logic [WIDTH-1:0] seed_clean;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] start;
    logic             step;
    logic             period_end;
    fsm_state_t       state_q;
    fsm_state_t       state_d;

    assign seed_clean = WIDTH'(sanitise_seed(32'(seed_in)));
    assign step       = en && !load;
    assign period_end = step && (next_state == start);
    assign prbs_bit   = lfsr_out[WIDTH-1];
    assign running    = (state_q == RUN);

    lfsr_core #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_VALUE(SEED_CLEAN)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .load_value(seed_clean),
        .state     (lfsr_out),
        .next_state(next_state)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (en)  state_d = RUN;
                RUN:     if (!en) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // start remembers where the current period began so the return can be spotted
    always_ff @(posedge clk) begin
        if (!reset) begin
            start    <= SEED_CLEAN;
            max_tick <= 1'b0;
        end else begin
            max_tick <= period_end;
            if (load) begin
                start <= seed_clean;
            end
        end
    end

`ifdef LFSR_STATS_EN
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] zeros_cnt;
    logic [CNT_W-1:0] ones_inc;
    logic [CNT_W-1:0] zeros_inc;

    // Saturating increment of whichever counter the outgoing bit selects
    always_comb begin
        ones_inc  = ones_cnt;
        zeros_inc = zeros_cnt;
        if (prbs_bit) begin
            if (ones_cnt != '1) ones_inc = ones_cnt + CNT_W'(1);
        end else begin
            if (zeros_cnt != '1) zeros_inc = zeros_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ones_cnt    <= '0;
            zeros_cnt   <= '0;
            final_ones  <= '0;
            final_zeros <= '0;
        end else if (load) begin
            ones_cnt  <= '0;
            zeros_cnt <= '0;
        end else if (step) begin
            if (period_end) begin
                final_ones  <= ones_inc;
                final_zeros <= zeros_inc;
                ones_cnt    <= '0;
                zeros_cnt   <= '0;
            end else begin
                ones_cnt  <= ones_inc;
                zeros_cnt <= zeros_inc;
            end
        end
    end
`else
    assign final_ones  = '0;
    assign final_zeros = '0;
`endif

endmodule

// File: tb/tb_lfsr_stat_gen.sv
// tb/tb_lfsr_stat_gen.sv - self-checking bench for lfsr_stat_gen (13-bit default and 4-bit instance)
module tb_lfsr_stat_gen;

`ifdef LFSR_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    localparam logic [12:0] TAPS13 = 13'h1C80;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [12:0] seed_in;
    logic [12:0] lfsr_out;
    logic        prbs_bit;
    logic        max_tick;
    logic [15:0] final_ones;
    logic [15:0] final_zeros;
    logic        running;

    logic        en4;
    logic        load4;
    logic [3:0]  seed4;
    logic [3:0]  lfsr4;
    logic        bit4;
    logic        tick4;
    logic [7:0]  fones4;
    logic [7:0]  fzeros4;
    logic        run4;

    int compared   = 0;
    int mismatched = 0;

    // behavioural reference state
    logic [12:0] m_state;
    logic [12:0] m_start;
    int          m_ones, m_zeros, m_fones, m_fzeros;
    logic        m_tick, m_run;

    int          step_cnt, tick_cnt, last_tick_step;
    logic [12:0] tick_lfsr;
    logic [15:0] tick_fo, tick_fz;

    always #5 clk = ~clk;

    lfsr_stat_gen dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .lfsr_out   (lfsr_out),
        .prbs_bit   (prbs_bit),
        .max_tick   (max_tick),
        .final_ones (final_ones),
        .final_zeros(final_zeros),
        .running    (running)
    );

    lfsr_stat_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .CNT_W(8)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .en         (en4),
        .load       (load4),
        .seed_in    (seed4),
        .lfsr_out   (lfsr4),
        .prbs_bit   (bit4),
        .max_tick   (tick4),
        .final_ones (fones4),
        .final_zeros(fzeros4),
        .running    (run4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare after the edge
    task automatic cyc(input logic r, input logic e, input logic l, input logic [12:0] s);
        logic b;
        logic [12:0] san;
        reset = r; en = e; load = l; seed_in = s;
        if (!r) begin
            m_state = 13'd1; m_start = 13'd1;
            m_ones = 0; m_zeros = 0; m_fones = 0; m_fzeros = 0;
            m_tick = 1'b0; m_run = 1'b0;
        end else if (l) begin
            san = (s == 13'd0) ? 13'd1 : s;
            m_state = san; m_start = san;
            m_ones = 0; m_zeros = 0;
            m_tick = 1'b0; m_run = 1'b0;
        end else if (e) begin
            b = m_state[12];
            m_state = 13'((m_state << 1) | 13'($countones(m_state & TAPS13) % 2));
            if (b) m_ones = (m_ones == 65535) ? m_ones : m_ones + 1;
            else   m_zeros = (m_zeros == 65535) ? m_zeros : m_zeros + 1;
            m_tick = (m_state == m_start);
            if (m_tick) begin
                m_fones = m_ones; m_fzeros = m_zeros;
                m_ones = 0; m_zeros = 0;
            end
            m_run = 1'b1;
            step_cnt++;
        end else begin
            m_tick = 1'b0; m_run = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("lfsr_out", 32'(lfsr_out), 32'(m_state));
        chk("bit", 32'(prbs_bit), 32'(m_state[12]));
        chk("max_tick", 32'(max_tick), 32'(m_tick));
        chk("running", 32'(running), 32'(m_run));
        chk("final_ones", 32'(final_ones), STATS != 0 ? m_fones : 0);
        chk("final_zeros", 32'(final_zeros), STATS != 0 ? m_fzeros : 0);
        if (max_tick === 1'b1) begin
            tick_cnt++;
            last_tick_step = step_cnt;
            tick_lfsr = lfsr_out;
            tick_fo = final_ones;
            tick_fz = final_zeros;
        end
    endtask

    task automatic clear_track();
        step_cnt = 0; tick_cnt = 0; last_tick_step = -1;
        tick_lfsr = '0; tick_fo = '0; tick_fz = '0;
    endtask

    task automatic check_period(input string tag, input logic [12:0] start_val);
        chk({tag, "_ticks"}, 32'(tick_cnt), 32'd1);
        chk({tag, "_tick_step"}, 32'(last_tick_step), 32'd8191);
        chk({tag, "_tick_lfsr"}, 32'(tick_lfsr), 32'(start_val));
        chk({tag, "_ones"}, 32'(tick_fo), STATS != 0 ? 32'd4096 : 32'd0);
        chk({tag, "_zeros"}, 32'(tick_fz), STATS != 0 ? 32'd4095 : 32'd0);
    endtask

    initial begin
        logic [12:0] rseed;
        logic [12:0] rstart;
        int guard;
        int first4;
        int ticks4;
        logic [3:0] lfsr4_at;
        logic [7:0] fo4_at, fz4_at;

        en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0;
        clear_track();

        // reset state
        cyc(1'b0, 1'b0, 1'b0, 13'h0);
        cyc(1'b0, 1'b1, 1'b0, 13'h0);
        chk("rst_lfsr", 32'(lfsr_out), 32'h1);
        chk("rst_bit", 32'(prbs_bit), 32'h0);
        chk("rst_tick", 32'(max_tick), 32'h0);
        chk("rst_fones", 32'(final_ones), 32'h0);
        chk("rst_fzeros", 32'(final_zeros), 32'h0);
        chk("rst_running", 32'(running), 32'h0);

        // one full period with en held high
        clear_track();
        for (int i = 0; i < 8191; i++) cyc(1'b1, 1'b1, 1'b0, 13'h0);
        check_period("full", 13'h0001);

        // zero seed sanitised, then load beats en on the same edge
        cyc(1'b1, 1'b0, 1'b1, 13'h0000);
        chk("load0_lfsr", 32'(lfsr_out), 32'h1);
        chk("load0_running", 32'(running), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 13'h0ABC);
        chk("loadabc_lfsr", 32'(lfsr_out), 32'h0ABC);
        chk("loadabc_running", 32'(running), 32'h0);
        clear_track();
        for (int i = 0; i < 8191; i++) cyc(1'b1, 1'b1, 1'b0, 13'h0);
        check_period("abc", 13'h0ABC);

        // random en gaps from a random seed
        rseed = 13'($urandom);
        rstart = (rseed == 13'd0) ? 13'd1 : rseed;
        cyc(1'b1, 1'b0, 1'b1, rseed);
        clear_track();
        guard = 0;
        while (step_cnt < 8191 && guard < 40000) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 13'h0);
            guard++;
        end
        chk("rand_steps", 32'(step_cnt), 32'd8191);
        check_period("rand", rstart);

        // reset mid-run discards partial counts
        cyc(1'b1, 1'b0, 1'b1, 13'h1234);
        for (int i = 0; i < 5000; i++) cyc(1'b1, 1'b1, 1'b0, 13'h0);
        cyc(1'b0, 1'b1, 1'b0, 13'h0);
        chk("midrst_lfsr", 32'(lfsr_out), 32'h1);
        chk("midrst_running", 32'(running), 32'h0);
        chk("midrst_fones", 32'(final_ones), 32'h0);
        clear_track();
        for (int i = 0; i < 8191; i++) cyc(1'b1, 1'b1, 1'b0, 13'h0);
        check_period("postrst", 13'h0001);

        // 4-bit instance: period 15, 8 ones / 7 zeros
        first4 = 0; ticks4 = 0;
        lfsr4_at = '0; fo4_at = '0; fz4_at = '0;
        for (int i = 1; i <= 30; i++) begin
            en4 = 1'b1;
            cyc(1'b1, 1'b0, 1'b0, 13'h0);
            if (tick4 === 1'b1) begin
                ticks4++;
                if (first4 == 0) begin
                    first4 = i; lfsr4_at = lfsr4; fo4_at = fones4; fz4_at = fzeros4;
                end
            end
        end
        en4 = 1'b0;
        chk("w4_first_tick", 32'(first4), 32'd15);
        chk("w4_ticks", 32'(ticks4), 32'd2);
        chk("w4_tick_lfsr", 32'(lfsr4_at), 32'h1);
        chk("w4_ones", 32'(fo4_at), STATS != 0 ? 32'd8 : 32'd0);
        chk("w4_zeros", 32'(fz4_at), STATS != 0 ? 32'd7 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_stat_gen.md
# lfsr_stat_gen

Parametrised Fibonacci LFSR pseudo-random generator with run-time seed load, clock enable and per-period ones/zeros statistics. It generalises the fixed 13-bit LFSR-with-counter to any width and tap polynomial. It is used as a PRBS source and a self-checking period monitor in test and data-whitening paths.

## Interface
- WIDTH, 13, LFSR length in bits (3..32)
- TAPS, 13'h1C80, feedback tap mask; bit i set = state bit i in XOR (default x^13+x^12+x^11+x^8+1)
- SEED, 1, reset seed; 0 replaced by 1
- CNT_W, 16, statistics counter width; must satisfy CNT_W ≥ WIDTH
- clk  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-low reset (acts on clk edge while 0)
- en  in  1  step enable; shift and count only when 1
- load  in  1  load seed_in this cycle; priority over en
- seed_in  in  WIDTH  runtime seed
- lfsr_out  out  WIDTH  current LFSR state
- bit  out  1  serial output = lfsr_out[WIDTH-1]
- max_tick  out  1  one-cycle pulse: state returned to period start value
- final_ones  out  CNT_W  ones counted over last complete period
- final_zeros  out  CNT_W  zeros counted over last complete period
- running  out  1  FSM in RUN

## Operation
- Feedback fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}
- Seed sanitising: seed of all-zeros loads as 1 (lock-up avoidance); applies to SEED and seed_in
- start register holds sanitised value from last reset/load; period end = state equals start after ≥1 step
- FSM states: IDLE, RUN
  - IDLE → RUN: en=1 (first step taken that edge)
  - RUN → IDLE: en=0 (state, counters frozen; no reset of statistics)
  - load in any state: state←seed, start←seed, running counters←0, final_* held, FSM→IDLE
- Counting: each stepping edge, running ones_cnt += bit, else zeros_cnt += 1 (value of bit before shift)
- Period end edge: final_ones/final_zeros ← running counts incl. this edge's bit; running counters ← 0; max_tick ← 1 for one cycle
- Counters saturate at 2^CNT_W-1 (non-maximal TAPS may exceed)
- Non-maximal TAPS: max_tick fires on actual cycle return; no polynomial check in hardware

## Timing
- Reset values: lfsr_out=sanitised SEED, bit=its MSB, max_tick=0, final_ones=0, final_zeros=0, running=0, running counters 0
- All outputs registered; lfsr_out updates 1 cycle after en/load edge
- Maximal polynomial: max_tick high exactly once per 2^WIDTH-1 stepping edges, in the same cycle lfsr_out==start; final_* valid from that cycle
- load and en together: load wins, no step that edge
- reset mid-run: everything returns to reset values next cycle, partial counts discarded
- en gaps do not affect period or counts; only stepping edges count

## Configuration
- LFSR_STATS_EN defined: ones/zeros counters and final_* registers built as above
- Not defined: counters removed, final_ones/final_zeros tied to 0; lfsr_out, bit, max_tick, running unchanged

## Structure
- Package lfsr_pkg: FSM state enum (IDLE, RUN), default tap mask constants for widths 3..32, sanitise-seed function
- Sub-module lfsr_core: state register, feedback, load/enable; top adds FSM, start compare, statistics

## Test plan
- Reset with defaults -> lfsr_out=13'h0001, bit=0, max_tick=0, final_ones=final_zeros=0, running=0
- en=1 for 8191 cycles -> single max_tick on cycle 8191 with lfsr_out=13'h0001, final_ones=4096, final_zeros=4095
- load=1, seed_in=0 -> lfsr_out=1 next cycle, running=0; load 13'h0ABC then 8191 steps -> max_tick with lfsr_out=13'h0ABC, 4096/4095
- en toggled 1/0 randomly over full period -> max_tick only after 8191 stepping edges, same final counts
- Reset asserted at step 5000 -> lfsr_out=1, counters 0; next full period still reports 4096/4095
- WIDTH=4, TAPS=4'hC, SEED=1 -> period 15, final_ones=8, final_zeros=7; without LFSR_STATS_EN final_* stay 0
